// File: rtl/vram_slot_arbiter_if.sv
// Bundle of requester, RAM and strobe signals around the VRAM slot arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vram_slot_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              ram_en;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [7:0]        vid_data;
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_slow;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_stall;
    logic              slow_strobe;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  ram_en, vid_req, vid_addr, cpu_req, cpu_we, cpu_slow,
               cpu_addr, cpu_wdata, mem_rdata,
        output vid_valid, vid_data, cpu_ack, cpu_rdata, cpu_stall,
               slow_strobe, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ram_en, vid_req, vid_addr, cpu_req, cpu_we, cpu_slow,
               cpu_addr, cpu_wdata, mem_rdata,
        input  vid_valid, vid_data, cpu_ack, cpu_rdata, cpu_stall,
               slow_strobe, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_slot_arbiter.sv
// Time-division video/CPU arbiter for the shared 32 KiB RAM, with slow-bus stretching.
// Optional macro SLOT_STEAL_EN lets fast CPU accesses use idle video slots.
module vram_slot_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int SLOW_DIV = 2
) (
    input logic                clk,
    input logic                RESET,
    vram_slot_arbiter_if.slave bus
);
    localparam int CNT_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [CNT_W-1:0]  SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SLOW_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK       = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             slot_cpu;
    logic [CNT_W-1:0] slow_cnt;
    logic [7:0]       rdata_hold;

    logic cpu_slot_p0;
    logic vid_slot_p0;
    logic vid_issue_p0;
    logic cpu_steal_p0;
    logic cpu_issue_p0;
    logic slow_fire_p0;
    logic vid_vld_p1;
    logic cpu_rd_p1;
    logic ack;

    // Stage p0: slot decode and RAM issue on the ram_en clk (slot value before toggle)
    assign cpu_slot_p0  = bus.ram_en & slot_cpu & ~RESET;
    assign vid_slot_p0  = bus.ram_en & ~slot_cpu & ~RESET;
    assign vid_issue_p0 = vid_slot_p0 & bus.vid_req;
`ifdef SLOT_STEAL_EN
    assign cpu_steal_p0 = vid_slot_p0 & ~bus.vid_req;
`else
    assign cpu_steal_p0 = 1'b0;
`endif
    assign cpu_issue_p0 = (state == ST_IDLE) & bus.cpu_req & ~bus.cpu_slow &
                          (cpu_slot_p0 | cpu_steal_p0);
    // A slow request landing directly on the strobe phase fires without waiting
    assign slow_fire_p0 = cpu_slot_p0 & bus.cpu_req & bus.cpu_slow &
                          (slow_cnt == SLOW_LAST) &
                          ((state == ST_IDLE) | (state == ST_SLOW_WAIT));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cpu_issue_p0 | slow_fire_p0)
                    state_nxt = ST_ACK;
                else if (cpu_slot_p0 & bus.cpu_req & bus.cpu_slow)
                    state_nxt = ST_SLOW_WAIT;
            end
            ST_SLOW_WAIT: if (slow_fire_p0) state_nxt = ST_ACK;
            ST_ACK:       state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    assign bus.mem_en      = vid_issue_p0 | cpu_issue_p0;
    assign bus.mem_we      = cpu_issue_p0 & bus.cpu_we;
    assign bus.mem_addr    = vid_issue_p0 ? bus.vid_addr :
                             (cpu_issue_p0 ? bus.cpu_addr : ADDR_ZERO);
    assign bus.mem_wdata   = (cpu_issue_p0 & bus.cpu_we) ? bus.cpu_wdata : 8'h00;
    assign bus.slow_strobe = slow_fire_p0;

    // Stage p1: read data returns from the synchronous RAM one clk after issue
    assign ack           = (state == ST_ACK) & ~RESET;
    assign bus.cpu_ack   = ack;
    assign bus.cpu_rdata = (ack & cpu_rd_p1) ? bus.mem_rdata : rdata_hold;
    assign bus.cpu_stall = bus.cpu_req & ~ack;
    assign bus.vid_valid = vid_vld_p1 & ~RESET;
    assign bus.vid_data  = (vid_vld_p1 & ~RESET) ? bus.mem_rdata : 8'h00;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= ST_IDLE;
            slot_cpu   <= 1'b0;
            slow_cnt   <= '0;
            vid_vld_p1 <= 1'b0;
            cpu_rd_p1  <= 1'b0;
            rdata_hold <= 8'h00;
        end else begin
            state      <= state_nxt;
            vid_vld_p1 <= vid_issue_p0;
            cpu_rd_p1  <= cpu_issue_p0 & ~bus.cpu_we;
            if (bus.ram_en)
                slot_cpu <= ~slot_cpu;
            if (cpu_slot_p0)
                slow_cnt <= (slow_cnt == SLOW_LAST) ? '0 : slow_cnt + 1'b1;
            if (ack & cpu_rd_p1)
                rdata_hold <= bus.mem_rdata;
        end
    end

`ifndef SYNTHESIS
    cpu_req_held_a: assert property (@(posedge clk) disable iff (RESET)
        (state != ST_IDLE) |-> bus.cpu_req);
    vid_req_held_a: assert property (@(posedge clk) disable iff (RESET)
        vid_vld_p1 |-> bus.vid_req);
    mem_gap_a: assert property (@(posedge clk) disable iff (RESET)
        bus.mem_en |=> !bus.mem_en);
`endif
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Scoreboard bench for vram_slot_arbiter: directed slot sequences push expected
// RAM/video/ack/strobe events; a negedge monitor pops and compares them.
module tb_vram_slot_arbiter;
    localparam int K_MEM = 0;
    localparam int K_VID = 1;
    localparam int K_ACK = 2;
    localparam int K_STB = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic        we;
        logic [14:0] addr;
        logic [7:0]  data;
        bit          chk_data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ev_count = 0;
    ev_t  q[$];

    logic [7:0] ram [0:32767];
    logic [7:0] rd_q = 8'h00;

    vram_slot_arbiter_if #(.ADDR_W(15)) bus ();

    vram_slot_arbiter #(.ADDR_W(15), .SLOW_DIV(2)) dut (
        .clk   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data one clk after mem_en
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            rd_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_ev(input int kind, input int off, input logic we,
                          input logic [14:0] addr, input logic [7:0] data, input bit cd);
        ev_t e;
        e.kind = kind; e.cyc = cyc + off; e.we = we;
        e.addr = addr; e.data = data; e.chk_data = cd;
        q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic we, input logic [14:0] addr,
                           input logic [7:0] data);
        ev_t e;
        bit  bad;
        ev_count++;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d at cyc %0d, expected none", kind, cyc);
        end else begin
            e = q.pop_front();
            bad = (e.kind != kind) || (e.cyc != cyc);
            if (kind == K_MEM) bad = bad || (e.we !== we) || (e.addr !== addr) ||
                                     (we && (e.data !== data));
            else if (e.chk_data) bad = bad || (e.data !== data);
            if (bad) begin
                errors++;
                $display("FAIL event: got kind=%0d cyc=%0d we=%0b addr=%0h data=%0h, expected kind=%0d cyc=%0d we=%0b addr=%0h data=%0h",
                         kind, cyc, we, addr, data, e.kind, e.cyc, e.we, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_en)      observe(K_MEM, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        if (bus.vid_valid)   observe(K_VID, 1'b0, 15'h0, bus.vid_data);
        if (bus.cpu_ack) begin
            observe(K_ACK, 1'b0, 15'h0, bus.cpu_rdata);
            chk("stall_at_ack", {31'b0, bus.cpu_stall}, 32'd0);
        end
        if (bus.slow_strobe) observe(K_STB, 1'b0, 15'h0, 8'h00);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_slot();
        bus.ram_en = 1'b1;
        tick();
        bus.ram_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic cpu_set(input logic req, input logic we, input logic slow,
                           input logic [14:0] addr, input logic [7:0] wd);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_slow = slow;
        bus.cpu_addr = addr; bus.cpu_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
        ram[15'h3000] = 8'hA5;
        ram[15'h7FFF] = 8'h3C;
        bus.ram_en = 1'b0; bus.vid_req = 1'b0; bus.vid_addr = 15'h0;
        cpu_set(1'b0, 1'b0, 1'b0, 15'h0, 8'h00);

        // Reset for 3 clks; outputs must all be zero
        tick(); tick();
        chk("reset_outputs",
            {bus.vid_valid, bus.cpu_ack, bus.cpu_stall, bus.slow_strobe, bus.mem_en,
             bus.mem_we, bus.mem_addr, bus.mem_wdata},
            32'd0);
        chk("reset_data", {16'b0, bus.vid_data, bus.cpu_rdata}, 32'd0);
        tick();
        rst = 1'b0;

        // Test 1: slots V,C,V,C with nothing pending
        repeat (4) ram_slot();
        chk("t1_quiet", ev_count, 32'd0);

        // Test 2: video fetch in V slot, then idle C slot
        bus.vid_req = 1'b1; bus.vid_addr = 15'h3000;
        exp_ev(K_MEM, 0, 1'b0, 15'h3000, 8'h00, 1'b0);
        exp_ev(K_VID, 1, 1'b0, 15'h0, 8'hA5, 1'b1);
        ram_slot();
        bus.vid_req = 1'b0;
        ram_slot();

        // Test 3: write 5C to 0100 in the C slot, then read it back
        ram_slot();
        cpu_set(1'b1, 1'b1, 1'b0, 15'h0100, 8'h5C);
        #1 chk("t3_stall_pending", {31'b0, bus.cpu_stall}, 32'd1);
        exp_ev(K_MEM, 0, 1'b1, 15'h0100, 8'h5C, 1'b0);
        exp_ev(K_ACK, 1, 1'b0, 15'h0, 8'h00, 1'b0);
        ram_slot();
        cpu_set(1'b0, 1'b0, 1'b0, 15'h0, 8'h00);
        #1 chk("t3_stall_clear", {31'b0, bus.cpu_stall}, 32'd0);
        ram_slot();
        cpu_set(1'b1, 1'b0, 1'b0, 15'h0100, 8'h00);
        exp_ev(K_MEM, 0, 1'b0, 15'h0100, 8'h00, 1'b0);
        exp_ev(K_ACK, 1, 1'b0, 15'h0, 8'h5C, 1'b1);
        ram_slot();
        cpu_set(1'b0, 1'b0, 1'b0, 15'h0, 8'h00);

        // Test 4: slow access raised with slow_cnt=0, strobe on the following C slot
        ram_slot(); ram_slot();
        cpu_set(1'b1, 1'b0, 1'b1, 15'h0, 8'h00);
        ram_slot(); ram_slot();
        chk("t4_stall_waiting", {31'b0, bus.cpu_stall}, 32'd1);
        ram_slot();
        exp_ev(K_STB, 0, 1'b0, 15'h0, 8'h00, 1'b0);
        exp_ev(K_ACK, 1, 1'b0, 15'h0, 8'h5C, 1'b1);
        ram_slot();
        cpu_set(1'b0, 1'b0, 1'b0, 15'h0, 8'h00);

        // Test 5: reset the clk after a CPU issue
        ram_slot();
        cpu_set(1'b1, 1'b0, 1'b0, 15'h0100, 8'h00);
        exp_ev(K_MEM, 0, 1'b0, 15'h0100, 8'h00, 1'b0);
        bus.ram_en = 1'b1;
        tick();
        bus.ram_en = 1'b0;
        rst = 1'b1;
        cpu_set(1'b0, 1'b0, 1'b0, 15'h0, 8'h00);
        #1 chk("t5_no_ack", {31'b0, bus.cpu_ack}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        chk("t5_stall_low", {31'b0, bus.cpu_stall}, 32'd0);
        bus.vid_req = 1'b1; bus.vid_addr = 15'h3000;
        exp_ev(K_MEM, 0, 1'b0, 15'h3000, 8'h00, 1'b0);
        exp_ev(K_VID, 1, 1'b0, 15'h0, 8'hA5, 1'b1);
        ram_slot();
        bus.vid_req = 1'b0;
        ram_slot();

        // Test 6: read 7FFF with the video slot unused
        cpu_set(1'b1, 1'b0, 1'b0, 15'h7FFF, 8'h00);
`ifdef SLOT_STEAL_EN
        exp_ev(K_MEM, 0, 1'b0, 15'h7FFF, 8'h00, 1'b0);
        exp_ev(K_ACK, 1, 1'b0, 15'h0, 8'h3C, 1'b1);
        ram_slot();
`else
        ram_slot();
        exp_ev(K_MEM, 0, 1'b0, 15'h7FFF, 8'h00, 1'b0);
        exp_ev(K_ACK, 1, 1'b0, 15'h0, 8'h3C, 1'b1);
        ram_slot();
`endif
        cpu_set(1'b0, 1'b0, 1'b0, 15'h0, 8'h00);
        repeat (4) tick();

        chk("events_outstanding", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
